// File: rtl/int_port_intake_queue.sv
// Per-port intake queue: captures dispatched uops assigned to PORT_IDX, keeps them in
// program order, issues the oldest one and truncates on a branch mispredict flush.
module int_port_intake_queue #(
    parameter int PORT_IDX  = 0,
    parameter int NUM_PORTS = 4,
    parameter int DEC_WIDTH = 4,
    parameter int DEPTH     = 8,
    parameter int SQN_W     = 7,
    parameter int UOP_W     = 64,
    localparam int ORD_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int PTR_W    = IDX_W + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       IN_valid,
    input  logic [DEC_WIDTH-1:0]       IN_uopValid,
    input  logic [DEC_WIDTH*ORD_W-1:0] IN_order,
    input  logic [DEC_WIDTH*SQN_W-1:0] IN_sqN,
    input  logic [DEC_WIDTH*UOP_W-1:0] IN_uop,
    input  logic                       IN_flushValid,
    input  logic [SQN_W-1:0]           IN_flushSqN,
    input  logic                       IN_issueReady,
    output logic                       OUT_issueValid,
    output logic [SQN_W-1:0]           OUT_issueSqN,
    output logic [UOP_W-1:0]           OUT_issueUop,
    output logic [PTR_W-1:0]           OUT_free,
    output logic                       OUT_overflow
);

    // Issue handshake: the head transfers on a rising edge where OUT_issueValid && IN_issueReady;
    // while ready is low the head valid/SqN/payload hold stable. There is no ready-to-valid path.

    logic [SQN_W-1:0] sqn_q [DEPTH];
    logic [UOP_W-1:0] uop_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr, wr_ptr, free_q;
    logic             overflow_q;
    logic [PTR_W-1:0] count;

    function automatic logic is_younger(input logic [SQN_W-1:0] s, input logic [SQN_W-1:0] f);
        logic [SQN_W-1:0] d;
        d = s - f;
        return !d[SQN_W-1] && (d != '0);
    endfunction

    assign count          = wr_ptr - rd_ptr;
    assign OUT_issueValid = (count != '0);
    assign OUT_issueSqN   = sqn_q[rd_ptr[IDX_W-1:0]];
    assign OUT_issueUop   = uop_q[rd_ptr[IDX_W-1:0]];
    assign OUT_free       = free_q;
    assign OUT_overflow   = overflow_q;

    // Contents are in program order, so the first younger entry marks the cut point.
    logic             flush_hit;
    logic [PTR_W-1:0] flush_ofs;

    always_comb begin
        flush_hit = 1'b0;
        flush_ofs = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!flush_hit && (PTR_W'(k) < count) &&
                is_younger(sqn_q[IDX_W'(rd_ptr + PTR_W'(k))], IN_flushSqN)) begin
                flush_hit = 1'b1;
                flush_ofs = PTR_W'(k);
            end
        end
    end

    logic flush_cut, head_killed, deq;

    assign flush_cut   = IN_flushValid && flush_hit;
    assign head_killed = flush_cut && (flush_ofs == '0);
    assign deq         = OUT_issueValid && IN_issueReady && !head_killed;

    // Lane compaction: each selected lane lands at wr_ptr + (selected lanes below it).
    logic [PTR_W-1:0] room, n_sel, n_wr;
    logic [DEC_WIDTH-1:0] lane_wr;
    logic [IDX_W-1:0] lane_idx [DEC_WIDTH];
    logic             ovf_now;

    assign room = PTR_W'(DEPTH) - count + PTR_W'(deq);

    always_comb begin
        n_sel   = '0;
        n_wr    = '0;
        lane_wr = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            lane_idx[i] = '0;
            if (IN_valid && !IN_flushValid && IN_uopValid[i] &&
                IN_order[i*ORD_W +: ORD_W] == ORD_W'(PORT_IDX)) begin
                if (n_sel < room) begin
                    lane_wr[i]  = 1'b1;
                    lane_idx[i] = IDX_W'(wr_ptr + n_sel);
                    n_wr        = n_wr + PTR_W'(1);
                end
                n_sel = n_sel + PTR_W'(1);
            end
        end
    end

    assign ovf_now = (n_sel > room);

    logic [PTR_W-1:0] rd_nxt, wr_nxt;

    assign rd_nxt = rd_ptr + PTR_W'(deq);
    assign wr_nxt = flush_cut ? (rd_ptr + flush_ofs) : (wr_ptr + n_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            free_q     <= PTR_W'(DEPTH);
            overflow_q <= 1'b0;
        end else begin
            rd_ptr     <= rd_nxt;
            wr_ptr     <= wr_nxt;
            free_q     <= PTR_W'(DEPTH) - (wr_nxt - rd_nxt);
            overflow_q <= overflow_q | ovf_now;
        end
    end

    // Entry storage carries no reset; validity comes only from the pointers.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEC_WIDTH; i++) begin
            if (lane_wr[i]) begin
                sqn_q[lane_idx[i]] <= IN_sqN[i*SQN_W +: SQN_W];
                uop_q[lane_idx[i]] <= IN_uop[i*UOP_W +: UOP_W];
            end
        end
    end

endmodule
